// File: rtl/ISO14443A_pkg.sv
// rtl/ISO14443A_pkg.sv - shared types and constants for the ISO14443A PCD->PICC receive path
package ISO14443A_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        FLUSH,
        ERROR
    } FrameDecodeState;

    localparam int BITS_PER_BYTE    = 8;
    localparam int SHORT_FRAME_BITS = 7;

    // One tick of upstream bit-stream activity; field order matches the input ports.
    typedef struct packed {
        logic soc;
        logic eoc;
        logic err;
        logic dv;
        logic data;
    } in_evt_t;

    function automatic logic odd_parity_ok(input logic [7:0] byte_v, input logic parity_bit);
        return (^byte_v) ^ parity_bit;
    endfunction

endpackage

// File: rtl/frame_decode.sv
// rtl/frame_decode.sv - assembles ISO14443-3 bit frames into bytes with odd-parity checking
module frame_decode
    import ISO14443A_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_soc,
    input  logic       in_eoc,
    input  logic       in_error,
    input  logic       in_data_valid,
    input  logic       in_data,
    output logic       out_soc,
    output logic       out_eoc,
    output logic       out_error,
    output logic       out_parity_error,
    output logic       out_data_valid,
    output logic [7:0] out_data,
    output logic [2:0] out_data_bits
);

    FrameDecodeState state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic [7:0]      shreg_q, shreg_d;
    in_evt_t         pend_q, pend_d;
    in_evt_t         live, eff;
    logic            soc_q, soc_d, eoc_q, eoc_d, err_q, err_d, perr_q, perr_d, dv_q, dv_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      bits_q, bits_d;

    // Anything arriving during FLUSH is held one tick and replayed, so no pulse is lost.
    always_comb begin
        live     = {in_soc, in_eoc, in_error, in_data_valid, in_data};
        eff.soc  = live.soc | pend_q.soc;
        eff.eoc  = live.eoc | pend_q.eoc;
        eff.err  = live.err | pend_q.err;
        eff.dv   = live.dv  | pend_q.dv;
        eff.data = pend_q.dv ? pend_q.data : live.data;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shreg_d = shreg_q;
        pend_d  = '0;
        soc_d   = 1'b0;
        eoc_d   = 1'b0;
        err_d   = 1'b0;
        perr_d  = 1'b0;
        dv_d    = 1'b0;
        data_d  = data_q;
        bits_d  = bits_q;
        case (state_q)
            IDLE: begin
                if (eff.soc) begin
                    soc_d   = 1'b1;
                    count_d = '0;
                    shreg_d = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (eff.err) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (eff.eoc) begin
                    if (count_q == 4'd0) begin
                        eoc_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Upper bits of shreg are already zero: it is cleared at every byte start.
                        dv_d    = 1'b1;
                        data_d  = shreg_q;
                        bits_d  = count_q[2:0];
                        state_d = FLUSH;
                    end
                end else if (eff.soc) begin
                    soc_d   = 1'b1;
                    count_d = '0;
                    shreg_d = '0;
                end else if (eff.dv) begin
                    shreg_d[count_q[2:0]] = eff.data;
                    count_d = count_q + 4'd1;
                    if (count_q == 4'(BITS_PER_BYTE - 1)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (eff.err) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (eff.eoc) begin
                    err_d   = 1'b1;
                    state_d = FLUSH;
                end else if (eff.soc) begin
                    soc_d   = 1'b1;
                    count_d = '0;
                    shreg_d = '0;
                    state_d = DATA;
                end else if (eff.dv) begin
                    if (odd_parity_ok(shreg_q, eff.data) || !CHECK_PARITY) begin
                        dv_d    = 1'b1;
                        data_d  = shreg_q;
                        bits_d  = '0;
                        count_d = '0;
                        shreg_d = '0;
                        state_d = DATA;
                    end else begin
                        err_d   = 1'b1;
                        perr_d  = 1'b1;
                        state_d = ERROR;
                    end
                end
            end
            FLUSH: begin
                eoc_d   = 1'b1;
                pend_d  = live;
                state_d = IDLE;
            end
            ERROR: begin
                if (eff.eoc) begin
                    eoc_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            shreg_q <= '0;
            pend_q  <= '0;
            soc_q   <= 1'b0;
            eoc_q   <= 1'b0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
            dv_q    <= 1'b0;
            data_q  <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            pend_q  <= pend_d;
            soc_q   <= soc_d;
            eoc_q   <= eoc_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
            dv_q    <= dv_d;
            data_q  <= data_d;
            bits_q  <= bits_d;
        end
    end

    assign out_soc          = soc_q;
    assign out_eoc          = eoc_q;
    assign out_error        = err_q;
    assign out_parity_error = perr_q;
    assign out_data_valid   = dv_q;
    assign out_data         = data_q;
    assign out_data_bits    = bits_q;

endmodule

// File: tb/tb_frame_decode.sv
// tb/tb_frame_decode.sv - scoreboard bench for frame_decode, parity-checking and non-checking builds
module tb_frame_decode;

    logic clk = 1'b0;
    logic rst;
    logic in_soc, in_eoc, in_error, in_data_valid, in_data;

    logic       a_soc, a_eoc, a_err, a_perr, a_dv;
    logic [7:0] a_data;
    logic [2:0] a_bits;
    logic       b_soc, b_eoc, b_err, b_perr, b_dv;
    logic [7:0] b_data;
    logic [2:0] b_bits;

    always #5 clk = ~clk;

    frame_decode #(.CHECK_PARITY(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .in_soc(in_soc), .in_eoc(in_eoc), .in_error(in_error),
        .in_data_valid(in_data_valid), .in_data(in_data),
        .out_soc(a_soc), .out_eoc(a_eoc), .out_error(a_err), .out_parity_error(a_perr),
        .out_data_valid(a_dv), .out_data(a_data), .out_data_bits(a_bits)
    );

    frame_decode #(.CHECK_PARITY(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .in_soc(in_soc), .in_eoc(in_eoc), .in_error(in_error),
        .in_data_valid(in_data_valid), .in_data(in_data),
        .out_soc(b_soc), .out_eoc(b_eoc), .out_error(b_err), .out_parity_error(b_perr),
        .out_data_valid(b_dv), .out_data(b_data), .out_data_bits(b_bits)
    );

    localparam logic [3:0] K_SOC = 4'b1000;
    localparam logic [3:0] K_EOC = 4'b0100;
    localparam logic [3:0] K_DV  = 4'b0010;
    localparam logic [3:0] K_ERR = 4'b0001;

    typedef struct {
        logic [3:0] kind;
        logic       perr;
        logic [7:0] data;
        logic [2:0] bits;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // who: 0 = both builds, 1 = parity-checking only, 2 = non-checking only
    task automatic expect_ev(input int who, input logic [3:0] k, input logic p,
                             input logic [7:0] d, input logic [2:0] b, input int lat);
        exp_t e;
        e.kind = k;
        e.perr = p;
        e.data = d;
        e.bits = b;
        e.cyc  = cyc + lat;
        if (who != 2) qa.push_back(e);
        if (who != 1) qb.push_back(e);
    endtask

    task automatic mon(input int who, input logic [3:0] k, input logic p,
                       input logic [7:0] d, input logic [2:0] b);
        exp_t e;
        if (k == 4'b0 && !p) return;
        checks++;
        if ((who == 0 && qa.size() == 0) || (who == 1 && qb.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_output dut%0d cyc=%0d kind=%b perr=%b data=%h bits=%0d",
                     who, cyc, k, p, d, b);
            return;
        end
        e = (who == 0) ? qa.pop_front() : qb.pop_front();
        if (k !== e.kind || p !== e.perr || cyc != e.cyc ||
            (e.kind == K_DV && (d !== e.data || b !== e.bits))) begin
            errors++;
            $display("FAIL output_event dut%0d got kind=%b perr=%b data=%h bits=%0d cyc=%0d, want kind=%b perr=%b data=%h bits=%0d cyc=%0d",
                     who, k, p, d, b, cyc, e.kind, e.perr, e.data, e.bits, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, {a_soc, a_eoc, a_dv, a_err}, a_perr, a_data, a_bits);
            mon(1, {b_soc, b_eoc, b_dv, b_err}, b_perr, b_data, b_bits);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic drv(input logic s, input logic e, input logic er, input logic dv, input logic d);
        in_soc = s; in_eoc = e; in_error = er; in_data_valid = dv; in_data = d;
        @(posedge clk); #1;
        in_soc = 0; in_eoc = 0; in_error = 0; in_data_valid = 0; in_data = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 1, v[i]);
    endtask

    task automatic drain(input string name);
        repeat (6) @(posedge clk);
        #1;
        chk({name, "_pending_a"}, qa.size(), 0);
        chk({name, "_pending_b"}, qb.size(), 0);
        qa.delete();
        qb.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_a"}, int'({a_soc, a_eoc, a_dv, a_err, a_perr, a_data, a_bits}), 0);
        chk({name, "_b"}, int'({b_soc, b_eoc, b_dv, b_err, b_perr, b_data, b_bits}), 0);
    endtask

    initial begin
        rst = 1; in_soc = 0; in_eoc = 0; in_error = 0; in_data_valid = 0; in_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;

        // REQA short frame: 7 bits -> 0x26
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h26, 7);
        expect_ev(0, K_DV, 0, 8'h26, 3'd7, 1);
        expect_ev(0, K_EOC, 0, 8'h00, 3'd0, 2); drv(0, 1, 0, 0, 0);
        drain("reqa");

        // SEL + NVB: 0x93 p=1, 0x20 p=0
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h93, 8);
        expect_ev(0, K_DV, 0, 8'h93, 3'd0, 1); drv(0, 0, 0, 1, 1);
        send_bits(8'h20, 8);
        expect_ev(0, K_DV, 0, 8'h20, 3'd0, 1); drv(0, 0, 0, 1, 0);
        expect_ev(0, K_EOC, 0, 8'h00, 3'd0, 1); drv(0, 1, 0, 0, 0);
        drain("sel_nvb");

        // Bad parity: checking build errors out, non-checking build keeps decoding
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h93, 8);
        expect_ev(1, K_ERR, 1, 8'h00, 3'd0, 1);
        expect_ev(2, K_DV, 0, 8'h93, 3'd0, 1); drv(0, 0, 0, 1, 0);
        send_bits(8'h09, 4);
        expect_ev(2, K_DV, 0, 8'h09, 3'd4, 1);
        expect_ev(2, K_EOC, 0, 8'h00, 3'd0, 2);
        expect_ev(1, K_EOC, 0, 8'h00, 3'd0, 1); drv(0, 1, 0, 0, 0);
        drain("parity_fail");

        // Anticollision: full byte then 3-bit partial 0x05
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h93, 8);
        expect_ev(0, K_DV, 0, 8'h93, 3'd0, 1); drv(0, 0, 0, 1, 1);
        send_bits(8'h05, 3);
        expect_ev(0, K_DV, 0, 8'h05, 3'd3, 1);
        expect_ev(0, K_EOC, 0, 8'h00, 3'd0, 2); drv(0, 1, 0, 0, 0);
        drain("anticoll");

        // Upstream timing error mid-byte; later bits ignored until eoc
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h0F, 3);
        expect_ev(0, K_ERR, 0, 8'h00, 3'd0, 1); drv(0, 0, 1, 0, 0);
        send_bits(8'hFF, 2);
        drv(1, 0, 0, 0, 0);
        expect_ev(0, K_EOC, 0, 8'h00, 3'd0, 1); drv(0, 1, 0, 0, 0);
        drain("in_error");

        // 8 bits with no parity bit: malformed error then eoc
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'hA5, 8);
        expect_ev(0, K_ERR, 0, 8'h00, 3'd0, 1);
        expect_ev(0, K_EOC, 0, 8'h00, 3'd0, 2); drv(0, 1, 0, 0, 0);
        drain("no_parity");

        // Idle: data, eoc and error are all ignored
        send_bits(8'hFF, 3);
        drv(0, 1, 0, 0, 0);
        drv(0, 0, 1, 0, 0);
        drain("idle_ignore");

        // Leave non-zero held data, then reset mid-frame
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h03, 2);
        expect_ev(0, K_DV, 0, 8'h03, 3'd2, 1);
        expect_ev(0, K_EOC, 0, 8'h00, 3'd0, 2); drv(0, 1, 0, 0, 0);
        drain("pre_reset");
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h0F, 4);
        drain("pre_reset_soc");
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("midframe_reset");
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h52, 7);
        expect_ev(0, K_DV, 0, 8'h52, 3'd7, 1);
        expect_ev(0, K_EOC, 0, 8'h00, 3'd0, 2); drv(0, 1, 0, 0, 0);
        drain("wupa_after_reset");

        // Restart mid-byte: partial byte dropped, second frame decodes
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h07, 3);
        expect_ev(0, K_SOC, 0, 8'h00, 3'd0, 1); drv(1, 0, 0, 0, 0);
        send_bits(8'h26, 7);
        expect_ev(0, K_DV, 0, 8'h26, 3'd7, 1);
        expect_ev(0, K_EOC, 0, 8'h00, 3'd0, 2); drv(0, 1, 0, 0, 0);
        drain("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
